pipe_seq_ctrl: RTL and testbench



---
 rtl/pipe_seq_ctrl_if.sv | 40 ++++
 rtl/pipe_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seq_ctrl_if
// Brief    : Hazard-in / pipeline-control-out bundle for pipe_seq_ctrl.
//            Optional perf counter outputs exist under PIPE_SEQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_seq_ctrl_if;
    logic        hzdlu;
    logic        ID_jnjr;
    logic        EX_jjr;
    logic        mdu_start;
    logic        mdu_done;
    logic [1:0]  pc_sel;
    logic        stall;
    logic [2:0]  flush;
    logic        mdu_busy;
    logic        mdu_tmo;
`ifdef PIPE_SEQ_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        output hzdlu, ID_jnjr, EX_jjr, mdu_start, mdu_done,
`ifdef PIPE_SEQ_PERF_EN
        input  perf_stall_cnt, perf_flush_cnt,
`endif
        input  pc_sel, stall, flush, mdu_busy, mdu_tmo
    );

    modport slave (
        input  hzdlu, ID_jnjr, EX_jjr, mdu_start, mdu_done,
`ifdef PIPE_SEQ_PERF_EN
        output perf_stall_cnt, perf_flush_cnt,
`endif
        output pc_sel, stall, flush, mdu_busy, mdu_tmo
    );
endinterface
`default_nettype wire

// File: rtl/pipe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seq_ctrl
// Brief    : Prioritised PC-select / stall / flush sequencer with boot clear
//            cycle and MDU wait-with-timeout. Macro PIPE_SEQ_PERF_EN adds
//            stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_seq_ctrl #(
    parameter int MDU_TMO = 64,
    parameter int CNT_W   = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_TMO = CNT_W'(MDU_TMO);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             tmo_q,   tmo_d;

    logic [1:0]       w_pc_sel;
    logic             w_stall;
    logic [2:0]       w_flush;
    logic             w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // The counter never passes c_TMO because reaching it forces the exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!bus.EX_jjr && bus.mdu_start) begin
                    state_d = MDU_WAIT;
                    cnt_d   = '0;
                end
            end
            MDU_WAIT: begin
                if (bus.mdu_done) begin
                    state_d = RUN;
                end else if (cnt_q == c_TMO) begin
                    state_d = RUN;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        w_pc_sel = 2'b00;
        w_stall  = 1'b0;
        w_flush  = 3'b000;
        w_busy   = 1'b0;
        case (state_q)
            BOOT: begin
                w_pc_sel = 2'b11;
                w_stall  = 1'b1;
                w_flush  = 3'b111;
            end
            RUN: begin
                if (bus.EX_jjr) begin
                    w_pc_sel = 2'b10;
                    w_flush  = 3'b011;
                end else if (bus.mdu_start) begin
                    w_pc_sel = 2'b11;
                    w_stall  = 1'b1;
                    w_flush  = 3'b100;
                end else if (bus.hzdlu) begin
                    w_pc_sel = 2'b11;
                    w_stall  = 1'b1;
                    w_flush  = 3'b010;
                end else if (bus.ID_jnjr) begin
                    w_pc_sel = 2'b01;
                    w_flush  = 3'b001;
                end
            end
            MDU_WAIT: begin
                w_pc_sel = 2'b11;
                w_stall  = 1'b1;
                w_flush  = 3'b100;
                w_busy   = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset must quiet the outputs immediately, not just once BOOT decodes.
    assign bus.pc_sel   = rst_n ? w_pc_sel : 2'b00;
    assign bus.stall    = rst_n ? w_stall  : 1'b0;
    assign bus.flush    = rst_n ? w_flush  : 3'b000;
    assign bus.mdu_busy = rst_n ? w_busy   : 1'b0;
    assign bus.mdu_tmo  = tmo_q;

`ifdef PIPE_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != BOOT) begin
            if (w_stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (w_flush != 3'b000)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_seq_ctrl
// Brief    : Scoreboard testbench for pipe_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_seq_ctrl;

    localparam int MDU_TMO = 64;

    typedef struct packed {
        logic [1:0] pc;
        logic       st;
        logic [2:0] fl;
        logic       busy;
        logic       tmo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    exp_t sb_q[$];

    // reference model state: 0 boot, 1 run, 2 mdu wait
    int   m_st;
    int   m_cnt;
    logic m_tmo;
`ifdef PIPE_SEQ_PERF_EN
    int   m_scnt;
    int   m_fcnt;
`endif

    pipe_seq_ctrl_if u_if ();

    pipe_seq_ctrl #(.MDU_TMO(MDU_TMO), .CNT_W(7)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        e.tmo = m_tmo;
        if (!rst_n) return e;
        if (m_st == 0) begin
            e.pc = 2'b11; e.st = 1'b1; e.fl = 3'b111;
        end else if (m_st == 2) begin
            e.pc = 2'b11; e.st = 1'b1; e.fl = 3'b100; e.busy = 1'b1;
        end else if (u_if.EX_jjr) begin
            e.pc = 2'b10; e.fl = 3'b011;
        end else if (u_if.mdu_start) begin
            e.pc = 2'b11; e.st = 1'b1; e.fl = 3'b100;
        end else if (u_if.hzdlu) begin
            e.pc = 2'b11; e.st = 1'b1; e.fl = 3'b010;
        end else if (u_if.ID_jnjr) begin
            e.pc = 2'b01; e.fl = 3'b001;
        end
        return e;
    endfunction

    task automatic model_step(input exp_t e);
`ifdef PIPE_SEQ_PERF_EN
        if (m_st != 0) begin
            if (e.st) m_scnt++;
            if (e.fl != 3'b000) m_fcnt++;
        end
`endif
        case (m_st)
            0: m_st = 1;
            1: if (!u_if.EX_jjr && u_if.mdu_start) begin m_st = 2; m_cnt = 0; end
            default: begin
                if (u_if.mdu_done) m_st = 1;
                else if (m_cnt == MDU_TMO) begin m_st = 1; m_tmo = 1'b1; end
                else m_cnt++;
            end
        endcase
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_pc_sel"}, 32'(u_if.pc_sel),   32'(e.pc));
        chk({tag, "_stall"},  32'(u_if.stall),    32'(e.st));
        chk({tag, "_flush"},  32'(u_if.flush),    32'(e.fl));
        chk({tag, "_busy"},   32'(u_if.mdu_busy), 32'(e.busy));
        chk({tag, "_tmo"},    32'(u_if.mdu_tmo),  32'(e.tmo));
    endtask

    // one clock cycle: drive at negedge, check combinational response, advance model
    task automatic cyc(input string tag, input logic jjr, input logic hz,
                       input logic jn, input logic st, input logic dn);
        exp_t e;
        @(negedge clk);
        u_if.EX_jjr    = jjr;
        u_if.hzdlu     = hz;
        u_if.ID_jnjr   = jn;
        u_if.mdu_start = st;
        u_if.mdu_done  = dn;
        e = model_out();
        sb_q.push_back(e);
        #1;
        sb_check(tag);
        model_step(e);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0);
    endtask

    // asynchronous assertion away from the edge, release just after a posedge
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        m_st = 0; m_cnt = 0; m_tmo = 1'b0;
`ifdef PIPE_SEQ_PERF_EN
        m_scnt = 0; m_fcnt = 0;
`endif
        sb_q.push_back(model_out());
        #1;
        sb_check("rst");
`ifdef PIPE_SEQ_PERF_EN
        chk("rst_perf_stall", u_if.perf_stall_cnt, 32'd0);
        chk("rst_perf_flush", u_if.perf_flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst_n = 1'b0;
        u_if.EX_jjr = 0; u_if.hzdlu = 0; u_if.ID_jnjr = 0;
        u_if.mdu_start = 0; u_if.mdu_done = 0;
        m_st = 0; m_cnt = 0; m_tmo = 1'b0;
`ifdef PIPE_SEQ_PERF_EN
        m_scnt = 0; m_fcnt = 0;
`endif

        do_reset();
        cyc("boot", 0, 0, 0, 0, 0);
        idle("run_idle", 2);

        cyc("hzd", 0, 1, 0, 0, 0);
        idle("hzd_after", 1);
        cyc("all3", 1, 1, 1, 0, 0);
        cyc("hzd_jn", 0, 1, 1, 0, 0);
        cyc("jn", 0, 0, 1, 0, 0);
        cyc("jjr_start", 1, 0, 0, 1, 0);
        cyc("stray_done", 0, 0, 0, 0, 1);

        cyc("mdu_start", 0, 0, 0, 1, 0);
        cyc("mdu_w1", 1, 1, 1, 1, 0);
        idle("mdu_w", 3);
        cyc("mdu_done", 0, 0, 0, 0, 1);
        idle("mdu_after", 1);

        cyc("sd_same", 0, 0, 0, 1, 1);
        cyc("sd_wait", 0, 0, 0, 0, 1);
        idle("sd_after", 1);

        cyc("tmo_start", 0, 0, 0, 1, 0);
        idle("tmo_wait", MDU_TMO + 1);
        idle("tmo_after", 1);
        cyc("tmo_late_done", 0, 0, 0, 0, 1);
        cyc("tmo_hzd", 0, 1, 0, 0, 0);

        do_reset();
        cyc("boot2", 0, 1, 1, 1, 0);
        cyc("run2", 0, 0, 0, 1, 0);
        idle("wait2", 3);
        do_reset();
        cyc("boot3", 1, 0, 0, 0, 0);
        idle("run3", 2);
`ifdef PIPE_SEQ_PERF_EN
        cyc("perf_hzd", 0, 1, 0, 0, 0);
        #1;
        chk("perf_stall", u_if.perf_stall_cnt, 32'(m_scnt));
        chk("perf_flush", u_if.perf_flush_cnt, 32'(m_fcnt));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
